// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   EX operand forwarding, ID load-use stall detection and a mul/div result
//   scoreboard with a cap on outstanding operations, plus saturating stall
//   statistics counters.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   id_*                 instruction in ID (valid, sources, used flags, rd, wen, mul/div)
//   pipe_adv_i           pipeline advances this cycle
//   ex_*, mem_*, wb_*    destination info of instructions in EX/MEM/WB
//   md_done_i, md_rd_i   mul/div completion and its destination
//   fwd_sel_o            per-source forward select (00 regfile, 01 MEM, 10 WB)
//   stall_id_o           hold PC/IF/ID
//   bubble_ex_o          load a NOP into ID/EX
//   sb_pending_o         per-register pending bits
//   md_outstanding_o     in-flight mul/div count
//   stat_loaduse_o       load-use stall cycles (saturating)
//   stat_sb_o            scoreboard/slot stall cycles (saturating)
module hazard_scoreboard_unit #(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned MD_SLOTS = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid_i,
    input  logic [NUM_SRC*5-1:0] id_rs_i,
    input  logic [NUM_SRC-1:0]   id_rs_used_i,
    input  logic [4:0]           id_rd_i,
    input  logic                 id_wen_i,
    input  logic                 id_is_muldiv_i,
    input  logic                 pipe_adv_i,
    input  logic [NUM_SRC*5-1:0] ex_rs_i,
    input  logic [4:0]           ex_rd_i,
    input  logic                 ex_wen_i,
    input  logic                 ex_is_load_i,
    input  logic [4:0]           mem_rd_i,
    input  logic                 mem_wen_i,
    input  logic                 mem_is_load_i,
    input  logic [4:0]           wb_rd_i,
    input  logic                 wb_wen_i,
    input  logic                 md_done_i,
    input  logic [4:0]           md_rd_i,
    output logic [NUM_SRC*2-1:0] fwd_sel_o,
    output logic                 stall_id_o,
    output logic                 bubble_ex_o,
    output logic [31:0]          sb_pending_o,
    output logic [3:0]           md_outstanding_o,
    output logic [CNT_W-1:0]     stat_loaduse_o,
    output logic [CNT_W-1:0]     stat_sb_o
);

    localparam logic [3:0]       SLOTS   = 4'(MD_SLOTS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      sb_q, sb_next;
    logic [3:0]       cnt_q, cnt_next;
    logic [CNT_W-1:0] stat_lu_q, stat_sb_q;
    logic             lu, raw, sbh, iss;

    // Forwarding: MEM (non-load) beats WB; x0 never forwarded.
    always_comb begin
        fwd_sel_o = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (mem_wen_i && !mem_is_load_i && mem_rd_i != 5'd0 &&
                mem_rd_i == ex_rs_i[5*k +: 5])
                fwd_sel_o[2*k +: 2] = 2'b01;
            else if (wb_wen_i && wb_rd_i != 5'd0 && wb_rd_i == ex_rs_i[5*k +: 5])
                fwd_sel_o[2*k +: 2] = 2'b10;
        end
    end

    // Hazard detection on the ID instruction.
    always_comb begin
        lu  = 1'b0;
        raw = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (id_rs_used_i[k]) begin
                if (ex_is_load_i && ex_wen_i && ex_rd_i != 5'd0 &&
                    id_rs_i[5*k +: 5] == ex_rd_i)
                    lu = 1'b1;
                if (sb_q[id_rs_i[5*k +: 5]])
                    raw = 1'b1;
            end
        end
        lu  = lu & id_valid_i;
        sbh = (id_valid_i && (raw || (id_wen_i && sb_q[id_rd_i]))) ||
              (id_is_muldiv_i && cnt_q == SLOTS);
    end

    assign stall_id_o  = lu | sbh;
    assign bubble_ex_o = stall_id_o & pipe_adv_i;
    assign iss         = id_valid_i & id_is_muldiv_i & ~stall_id_o & pipe_adv_i;

    // Clear first, then set, so an issue to the same register wins.
    always_comb begin
        sb_next = sb_q;
        if (md_done_i)
            sb_next[md_rd_i] = 1'b0;
        if (iss && id_rd_i != 5'd0)
            sb_next[id_rd_i] = 1'b1;
        sb_next[0] = 1'b0;

        cnt_next = cnt_q;
        unique case ({iss, md_done_i})
            2'b10:   if (cnt_q != SLOTS) cnt_next = cnt_q + 4'd1;
            2'b01:   if (cnt_q != 4'd0)  cnt_next = cnt_q - 4'd1;
            default: cnt_next = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q      <= '0;
            cnt_q     <= '0;
            stat_lu_q <= '0;
            stat_sb_q <= '0;
        end else begin
            sb_q  <= sb_next;
            cnt_q <= cnt_next;
            if (lu && pipe_adv_i && stat_lu_q != '1)
                stat_lu_q <= stat_lu_q + CNT_ONE;
            if (sbh && !lu && pipe_adv_i && stat_sb_q != '1)
                stat_sb_q <= stat_sb_q + CNT_ONE;
        end
    end

    assign sb_pending_o     = sb_q;
    assign md_outstanding_o = cnt_q;
    assign stat_loaduse_o   = stat_lu_q;
    assign stat_sb_o        = stat_sb_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit (NUM_SRC=2, MD_SLOTS=2, CNT_W=4).
module tb_hazard_scoreboard_unit;

    localparam int NS = 2;
    localparam int SL = 2;
    localparam int CW = 4;

    localparam int S_FWD = 0, S_STALL = 1, S_BUB = 2, S_PEND = 3,
                   S_OUT = 4, S_LU = 5, S_SB = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            id_valid;
    logic [NS*5-1:0] id_rs;
    logic [NS-1:0]   id_used;
    logic [4:0]      id_rd;
    logic            id_wen, id_md, pipe_adv;
    logic [NS*5-1:0] ex_rs;
    logic [4:0]      ex_rd;
    logic            ex_wen, ex_ld;
    logic [4:0]      mem_rd;
    logic            mem_wen, mem_ld;
    logic [4:0]      wb_rd;
    logic            wb_wen;
    logic            md_done;
    logic [4:0]      md_rd;
    logic [NS*2-1:0] fwd_sel;
    logic            stall, bubble;
    logic [31:0]     pending;
    logic [3:0]      outstanding;
    logic [CW-1:0]   stat_lu, stat_sb;

    hazard_scoreboard_unit #(.NUM_SRC(NS), .MD_SLOTS(SL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rs_used_i(id_used),
        .id_rd_i(id_rd), .id_wen_i(id_wen), .id_is_muldiv_i(id_md),
        .pipe_adv_i(pipe_adv),
        .ex_rs_i(ex_rs), .ex_rd_i(ex_rd), .ex_wen_i(ex_wen), .ex_is_load_i(ex_ld),
        .mem_rd_i(mem_rd), .mem_wen_i(mem_wen), .mem_is_load_i(mem_ld),
        .wb_rd_i(wb_rd), .wb_wen_i(wb_wen),
        .md_done_i(md_done), .md_rd_i(md_rd),
        .fwd_sel_o(fwd_sel), .stall_id_o(stall), .bubble_ex_o(bubble),
        .sb_pending_o(pending), .md_outstanding_o(outstanding),
        .stat_loaduse_o(stat_lu), .stat_sb_o(stat_sb)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [9:0] ex_rs;
        logic [4:0] mem_rd;
        logic       mem_wen;
        logic       mem_ld;
        logic [4:0] wb_rd;
        logic       wb_wen;
        logic [3:0] exp_fwd;
    } fv_t;

    exp_t sbq[$];
    fv_t  fv[8];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] get_out(input int sel);
        case (sel)
            S_FWD:   return 32'(fwd_sel);
            S_STALL: return 32'(stall);
            S_BUB:   return 32'(bubble);
            S_PEND:  return pending;
            S_OUT:   return 32'(outstanding);
            S_LU:    return 32'(stat_lu);
            S_SB:    return 32'(stat_sb);
            default: return 32'hdeadbeef;
        endcase
    endfunction

    task automatic exp_out(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sbq.push_back(e);
    endtask

    // Compare all queued expectations mid-cycle, then advance one clock.
    task automatic cyc();
        exp_t e;
        logic [31:0] act;
        @(negedge clk);
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = get_out(e.sel);
            n_cmp++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = '0; id_used = '0; id_rd = '0; id_wen = 0; id_md = 0;
        pipe_adv = 1;
        ex_rs = '0; ex_rd = '0; ex_wen = 0; ex_ld = 0;
        mem_rd = '0; mem_wen = 0; mem_ld = 0;
        wb_rd = '0; wb_wen = 0;
        md_done = 0; md_rd = '0;
    endtask

    task automatic mul(input logic [4:0] rd);
        id_valid = 1; id_md = 1; id_wen = 1; id_rd = rd; id_used = '0; id_rs = '0;
    endtask

    task automatic st(input string tag, input logic s, input logic b,
                      input logic [31:0] p, input logic [3:0] o);
        exp_out({tag, "_stall"}, S_STALL, 32'(s));
        exp_out({tag, "_bubble"}, S_BUB, 32'(b));
        exp_out({tag, "_pend"}, S_PEND, p);
        exp_out({tag, "_out"}, S_OUT, 32'(o));
    endtask

    initial begin
        fv[0] = '{ {5'd0, 5'd5},  5'd5,  1'b1, 1'b0, 5'd5,  1'b1, 4'b0001 };
        fv[1] = '{ {5'd0, 5'd5},  5'd5,  1'b1, 1'b1, 5'd5,  1'b1, 4'b0010 };
        fv[2] = '{ {5'd5, 5'd0},  5'd5,  1'b1, 1'b0, 5'd5,  1'b1, 4'b0100 };
        fv[3] = '{ {5'd0, 5'd0},  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 4'b0000 };
        fv[4] = '{ {5'd3, 5'd7},  5'd7,  1'b1, 1'b0, 5'd3,  1'b1, 4'b1001 };
        fv[5] = '{ {5'd3, 5'd7},  5'd7,  1'b0, 1'b0, 5'd7,  1'b1, 4'b0010 };
        fv[6] = '{ {5'd31, 5'd31}, 5'd31, 1'b0, 1'b0, 5'd31, 1'b0, 4'b0000 };
        fv[7] = '{ {5'd31, 5'd31}, 5'd31, 1'b1, 1'b0, 5'd31, 1'b1, 4'b0101 };

        idle();
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;

        // Reset state
        st("rst", 0, 0, 32'h0, 4'd0);
        exp_out("rst_lu", S_LU, 0);
        exp_out("rst_sb", S_SB, 0);
        cyc();

        // Forwarding table
        for (int i = 0; i < 8; i++) begin
            idle();
            ex_rs = fv[i].ex_rs; mem_rd = fv[i].mem_rd; mem_wen = fv[i].mem_wen;
            mem_ld = fv[i].mem_ld; wb_rd = fv[i].wb_rd; wb_wen = fv[i].wb_wen;
            exp_out($sformatf("fwd%0d", i), S_FWD, 32'(fv[i].exp_fwd));
            exp_out($sformatf("fwd%0d_stall", i), S_STALL, 0);
            cyc();
        end

        // Load-use
        idle();
        id_valid = 1; id_rs = {5'd0, 5'd7}; id_used = 2'b01; id_wen = 1; id_rd = 5'd8;
        ex_ld = 1; ex_wen = 1; ex_rd = 5'd7;
        st("lu1", 1, 1, 32'h0, 4'd0); exp_out("lu1_cnt", S_LU, 0); cyc();
        ex_ld = 0; ex_wen = 0; ex_rd = 5'd0;
        st("lu2", 0, 0, 32'h0, 4'd0); exp_out("lu2_cnt", S_LU, 1); cyc();
        ex_ld = 1; ex_wen = 1; ex_rd = 5'd7; id_rs = {5'd7, 5'd0}; id_used = 2'b01;
        st("lu3", 0, 0, 32'h0, 4'd0); exp_out("lu3_cnt", S_LU, 1); cyc();
        id_used = 2'b10;
        st("lu4", 1, 1, 32'h0, 4'd0); cyc();
        ex_rd = 5'd0; id_rs = '0; id_used = 2'b11;
        st("lu5", 0, 0, 32'h0, 4'd0); exp_out("lu5_cnt", S_LU, 2); cyc();
        ex_rd = 5'd7; ex_wen = 0; id_rs = {5'd0, 5'd7}; id_used = 2'b01;
        st("lu6", 0, 0, 32'h0, 4'd0); cyc();

        // Scoreboard RAW
        idle(); mul(5'd9);
        st("raw0", 0, 0, 32'h0, 4'd0); cyc();
        idle(); id_valid = 1; id_rs = {5'd0, 5'd9}; id_used = 2'b01; id_wen = 1; id_rd = 5'd10;
        st("raw1", 1, 1, 32'h200, 4'd1); exp_out("raw1_sb", S_SB, 0); cyc();
        st("raw2", 1, 1, 32'h200, 4'd1); exp_out("raw2_sb", S_SB, 1); cyc();
        md_done = 1; md_rd = 5'd9;
        st("raw3", 1, 1, 32'h200, 4'd1); exp_out("raw3_sb", S_SB, 2); cyc();
        md_done = 0;
        st("raw4", 0, 0, 32'h0, 4'd0); exp_out("raw4_sb", S_SB, 3); cyc();

        // Scoreboard WAW and frozen pipe
        idle(); mul(5'd9);
        st("waw0", 0, 0, 32'h0, 4'd0); cyc();
        idle(); id_valid = 1; id_wen = 1; id_rd = 5'd9;
        st("waw1", 1, 1, 32'h200, 4'd1); exp_out("waw1_sb", S_SB, 3); cyc();
        pipe_adv = 0;
        st("waw2", 1, 0, 32'h200, 4'd1); exp_out("waw2_sb", S_SB, 4); cyc();
        idle(); md_done = 1; md_rd = 5'd9;
        st("waw3", 0, 0, 32'h200, 4'd1); exp_out("waw3_sb", S_SB, 4); cyc();

        // Slot limit and simultaneous events
        idle(); mul(5'd4);
        st("sl0", 0, 0, 32'h0, 4'd0); cyc();
        mul(5'd5);
        st("sl1", 0, 0, 32'h10, 4'd1); cyc();
        mul(5'd6);
        st("sl2", 1, 1, 32'h30, 4'd2); exp_out("sl2_sb", S_SB, 4); cyc();
        idle(); md_done = 1; md_rd = 5'd4;
        st("sl3", 0, 0, 32'h30, 4'd2); exp_out("sl3_sb", S_SB, 5); cyc();
        mul(5'd4); md_done = 1; md_rd = 5'd4;
        st("sl4", 0, 0, 32'h20, 4'd1); cyc();
        mul(5'd6); md_done = 1; md_rd = 5'd5;
        st("sl5", 0, 0, 32'h30, 4'd1); cyc();
        idle(); md_done = 1; md_rd = 5'd4;
        st("sl6", 0, 0, 32'h50, 4'd1); cyc();
        md_rd = 5'd6;
        st("sl7", 0, 0, 32'h40, 4'd0); cyc();
        md_rd = 5'd7;
        st("sl8", 0, 0, 32'h0, 4'd0); cyc();
        idle(); mul(5'd0);
        st("sl9", 0, 0, 32'h0, 4'd0); cyc();
        idle(); md_done = 1; md_rd = 5'd0;
        st("sl10", 0, 0, 32'h0, 4'd1); cyc();
        idle();
        st("sl11", 0, 0, 32'h0, 4'd0); exp_out("sl11_sb", S_SB, 5); cyc();

        // Load-use counter saturation
        idle();
        id_valid = 1; id_rs = {5'd0, 5'd7}; id_used = 2'b01;
        ex_ld = 1; ex_wen = 1; ex_rd = 5'd7;
        for (int i = 0; i < 20; i++) begin
            exp_out($sformatf("sat%0d_lu", i), S_LU, 32'((2 + i > 15) ? 15 : 2 + i));
            exp_out($sformatf("sat%0d_bubble", i), S_BUB, 1);
            cyc();
        end
        pipe_adv = 0;
        st("frz0", 1, 0, 32'h0, 4'd0); exp_out("frz0_lu", S_LU, 15); cyc();
        exp_out("frz1_lu", S_LU, 15); exp_out("frz1_sb", S_SB, 5); cyc();

        // Reset mid-operation
        idle(); mul(5'd9);
        st("mr0", 0, 0, 32'h0, 4'd0); cyc();
        mul(5'd11); md_done = 1; md_rd = 5'd3; rst = 1;
        st("mr1", 0, 0, 32'h200, 4'd1); cyc();
        rst = 0; idle();
        st("mr2", 0, 0, 32'h0, 4'd0);
        exp_out("mr2_lu", S_LU, 0);
        exp_out("mr2_sb", S_SB, 0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
